// File: rtl/can_form_checker.sv
// CAN form-error checker: validates CRC delimiter, ACK delimiter and EOF bits at each
// sample point, with EOF bit counting, error capture and a saturating error counter.
module can_form_checker #(
  parameter int EOF_LEN   = 7,
  parameter int CNT_W     = 8,
  parameter bit ERR_LATCH = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sp,
  input  logic             rx,
  input  logic [1:0]       field,
  input  logic             receiver_mode,
  input  logic             clear,
  output logic             form_err_n,
  output logic             form_err_pulse,
  output logic [1:0]       err_field,
  output logic             overload_req,
  output logic             eof_done,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {IDLE, CHECK, ERROR} state_t;

  localparam int               EW       = $clog2(EOF_LEN + 1);
  localparam logic [1:0]       F_NONE   = 2'd0;
  localparam logic [1:0]       F_CRC    = 2'd1;
  localparam logic [1:0]       F_ACK    = 2'd2;
  localparam logic [1:0]       F_EOF    = 2'd3;
  localparam logic [EW-1:0]    EOF_LAST = EW'(EOF_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t        state;
  logic [EW-1:0] eof_cnt;

  logic          checking;
  logic          eof_new;
  logic [EW-1:0] eof_k;
  logic          last_bit;
  logic          delim_err;
  logic          eof_err;
  logic          form_err;
  logic          done_next;
  logic          ovl_next;
  logic [CNT_W-1:0] cnt_base;

  // eof_new marks an EOF bit that is still inside the checked window
  assign checking  = (state != ERROR);
  assign eof_new   = (field == F_EOF) && (eof_cnt != EOF_LAST);
  assign eof_k     = eof_cnt + EW'(1);
  assign last_bit  = eof_new && (eof_k == EOF_LAST);
  assign delim_err = ((field == F_CRC) || (field == F_ACK)) && !rx;
  assign eof_err   = eof_new && !rx && (!last_bit || !receiver_mode);
  assign form_err  = sp && checking && (delim_err || eof_err);
  assign done_next = sp && checking && last_bit && !eof_err;
  assign ovl_next  = sp && checking && last_bit && !rx && receiver_mode;
  assign cnt_base  = clear ? '0 : err_count;

  // NOTE: all state here uses non-blocking assignments so every register samples
  // the pre-edge values; blocking would make later statements see updated state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      eof_cnt        <= '0;
      form_err_n     <= 1'b1;
      form_err_pulse <= 1'b0;
      err_field      <= F_NONE;
      overload_req   <= 1'b0;
      eof_done       <= 1'b0;
      err_count      <= '0;
    end else begin
      form_err_pulse <= form_err;
      overload_req   <= ovl_next;
      eof_done       <= done_next;

      if (sp) begin
        if (field == F_EOF) begin
          if (eof_new) eof_cnt <= eof_k;
        end else begin
          eof_cnt <= '0;
        end
      end

      if (clear) begin
        form_err_n <= 1'b1;
        err_field  <= F_NONE;
        err_count  <= '0;
      end

      // A new error overrides a simultaneous clear
      if (form_err) begin
        form_err_n <= 1'b0;
        err_field  <= field;
        err_count  <= (cnt_base == CNT_MAX) ? cnt_base : cnt_base + CNT_W'(1);
      end

      if (sp) begin
        case (state)
          IDLE, CHECK: begin
            if (form_err)              state <= ERROR;
            else if (field != F_NONE)  state <= CHECK;
            else                       state <= IDLE;
          end
          ERROR: begin
            if (field == F_NONE) begin
              state <= IDLE;
              if (!ERR_LATCH) form_err_n <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_can_form_checker.sv
// Bench for can_form_checker: three configurations share one stimulus stream and are
// compared each cycle against a per-sample-point behavioural model.
module tb_can_form_checker;

  localparam int N = 3;
  localparam logic [1:0] NONE = 2'd0, CRC = 2'd1, ACK = 2'd2, EOF = 2'd3;

  int p_len   [N] = '{7, 7, 3};
  int p_max   [N] = '{255, 3, 3};
  int p_latch [N] = '{1, 0, 0};

  logic clk = 1'b0;
  logic reset, sp, rx, receiver_mode, clear;
  logic [1:0] field;

  logic       o_n    [N];
  logic       o_p    [N];
  logic [1:0] o_fld  [N];
  logic       o_ovl  [N];
  logic       o_done [N];
  logic [7:0] o_cnt  [N];
  logic [7:0] c0;
  logic [1:0] c1, c2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  can_form_checker #(.EOF_LEN(7), .CNT_W(8), .ERR_LATCH(1'b1)) u0 (
    .clk(clk), .reset(reset), .sp(sp), .rx(rx), .field(field),
    .receiver_mode(receiver_mode), .clear(clear), .form_err_n(o_n[0]),
    .form_err_pulse(o_p[0]), .err_field(o_fld[0]), .overload_req(o_ovl[0]),
    .eof_done(o_done[0]), .err_count(c0));
  can_form_checker #(.EOF_LEN(7), .CNT_W(2), .ERR_LATCH(1'b0)) u1 (
    .clk(clk), .reset(reset), .sp(sp), .rx(rx), .field(field),
    .receiver_mode(receiver_mode), .clear(clear), .form_err_n(o_n[1]),
    .form_err_pulse(o_p[1]), .err_field(o_fld[1]), .overload_req(o_ovl[1]),
    .eof_done(o_done[1]), .err_count(c1));
  can_form_checker #(.EOF_LEN(3), .CNT_W(2), .ERR_LATCH(1'b0)) u2 (
    .clk(clk), .reset(reset), .sp(sp), .rx(rx), .field(field),
    .receiver_mode(receiver_mode), .clear(clear), .form_err_n(o_n[2]),
    .form_err_pulse(o_p[2]), .err_field(o_fld[2]), .overload_req(o_ovl[2]),
    .eof_done(o_done[2]), .err_count(c2));

  assign o_cnt[0] = c0;
  assign o_cnt[1] = {6'b0, c1};
  assign o_cnt[2] = {6'b0, c2};

  // Reference model: what each sample point means under the protocol rules
  int m_n [N], m_p [N], m_fld [N], m_ovl [N], m_done [N], m_cnt [N];
  int m_bits [N];
  bit m_in_err [N];

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        m_n[i] = 1; m_p[i] = 0; m_fld[i] = 0; m_ovl[i] = 0; m_done[i] = 0;
        m_cnt[i] = 0; m_bits[i] = 0; m_in_err[i] = 1'b0;
      end else begin
        m_p[i] = 0; m_ovl[i] = 0; m_done[i] = 0;
        if (clear) begin
          m_n[i] = 1; m_fld[i] = 0; m_cnt[i] = 0;
        end
        if (sp) begin
          int  k;
          bit  err;
          k   = 0;
          err = 1'b0;
          if (field == EOF) begin
            if (m_bits[i] < p_len[i]) begin
              m_bits[i]++;
              k = m_bits[i];
            end
          end else begin
            m_bits[i] = 0;
          end
          if (!m_in_err[i]) begin
            if ((field == CRC || field == ACK) && !rx) err = 1'b1;
            if (k != 0) begin
              if (!rx && (k < p_len[i] || !receiver_mode)) err = 1'b1;
              else if (k == p_len[i]) begin
                m_done[i] = 1;
                if (!rx) m_ovl[i] = 1;
              end
            end
            if (err) begin
              m_p[i] = 1; m_n[i] = 0; m_fld[i] = field;
              m_cnt[i] = (m_cnt[i] + 1 > p_max[i]) ? p_max[i] : m_cnt[i] + 1;
              m_in_err[i] = 1'b1;
            end
          end else if (field == NONE) begin
            m_in_err[i] = 1'b0;
            if (p_latch[i] == 0) m_n[i] = 1;
          end
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: outputs are stable at the falling edge
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      check($sformatf("u%0d.form_err_n", i), int'(o_n[i]), m_n[i]);
      check($sformatf("u%0d.form_err_pulse", i), int'(o_p[i]), m_p[i]);
      check($sformatf("u%0d.err_field", i), int'(o_fld[i]), m_fld[i]);
      check($sformatf("u%0d.overload_req", i), int'(o_ovl[i]), m_ovl[i]);
      check($sformatf("u%0d.eof_done", i), int'(o_done[i]), m_done[i]);
      check($sformatf("u%0d.err_count", i), int'(o_cnt[i]), m_cnt[i]);
    end
  end

  // One clock of stimulus; on return the outputs reflect that clock
  task automatic cyc(input logic s, input logic r, input logic [1:0] f, input logic c);
    sp = s; rx = r; field = f; clear = c;
    @(negedge clk); #1;
  endtask

  task automatic spb(input logic r, input logic [1:0] f);
    cyc(1'b0, 1'b1, f, 1'b0);
    cyc(1'b1, r, f, 1'b0);
  endtask

  task automatic do_clear();
    cyc(1'b0, 1'b1, NONE, 1'b1);
  endtask

  initial begin
    reset = 1'b1; sp = 1'b0; rx = 1'b1; field = NONE; clear = 1'b0; receiver_mode = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    cyc(1'b0, 1'b1, NONE, 1'b0);
    check("rst form_err_n", int'(o_n[0]), 1);
    check("rst err_count", int'(o_cnt[0]), 0);

    // Reset in the middle of an EOF, then a full recessive EOF
    spb(1'b1, NONE);
    for (int i = 0; i < 4; i++) spb(1'b1, EOF);
    reset = 1'b1;
    @(negedge clk); #1 reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      spb(1'b1, EOF);
      check($sformatf("eof7 done k=%0d", i), int'(o_done[0]), (i == 7) ? 1 : 0);
    end
    cyc(1'b0, 1'b1, EOF, 1'b0);
    check("eof7 done width", int'(o_done[0]), 0);
    check("eof7 form_err_n", int'(o_n[0]), 1);
    check("eof7 err_count", int'(o_cnt[0]), 0);

    // ACK delimiter error, then a second dominant bit while in ERROR
    spb(1'b1, NONE);
    spb(1'b0, ACK);
    check("ack pulse", int'(o_p[0]), 1);
    check("ack form_err_n", int'(o_n[0]), 0);
    check("ack err_field", int'(o_fld[0]), 2);
    check("ack err_count", int'(o_cnt[0]), 1);
    spb(1'b0, ACK);
    check("ack2 pulse", int'(o_p[0]), 0);
    check("ack2 err_count", int'(o_cnt[0]), 1);
    spb(1'b1, NONE);
    check("latch1 held", int'(o_n[0]), 0);
    check("latch0 released", int'(o_n[1]), 1);
    do_clear();
    check("clear form_err_n", int'(o_n[0]), 1);
    check("clear err_field", int'(o_fld[0]), 0);

    // Last EOF bit dominant: overload as receiver, form error as transmitter
    receiver_mode = 1'b1;
    for (int i = 0; i < 6; i++) spb(1'b1, EOF);
    spb(1'b0, EOF);
    check("ovl overload_req", int'(o_ovl[0]), 1);
    check("ovl eof_done", int'(o_done[0]), 1);
    check("ovl pulse", int'(o_p[0]), 0);
    spb(1'b1, NONE);
    receiver_mode = 1'b0;
    for (int i = 0; i < 6; i++) spb(1'b1, EOF);
    spb(1'b0, EOF);
    check("tx eof pulse", int'(o_p[0]), 1);
    check("tx eof err_field", int'(o_fld[0]), 3);
    check("tx eof done", int'(o_done[0]), 0);
    check("tx eof overload", int'(o_ovl[0]), 0);
    spb(1'b1, NONE);
    do_clear();

    // Latching vs auto-release after a CRC delimiter error
    spb(1'b0, CRC);
    check("crc latch1 n", int'(o_n[0]), 0);
    check("crc latch0 n", int'(o_n[1]), 0);
    spb(1'b1, NONE);
    check("crc latch0 release", int'(o_n[1]), 1);
    check("crc latch1 hold", int'(o_n[0]), 0);
    do_clear();
    check("crc latch1 clear", int'(o_n[0]), 1);

    // Counter saturation, then clear colliding with a new error
    for (int i = 0; i < 5; i++) begin
      spb(1'b0, ACK);
      spb(1'b1, NONE);
    end
    check("sat cnt2", int'(o_cnt[1]), 3);
    check("sat cnt8", int'(o_cnt[0]), 5);
    cyc(1'b0, 1'b1, ACK, 1'b0);
    cyc(1'b1, 1'b0, ACK, 1'b1);
    check("clr+err cnt", int'(o_cnt[1]), 1);
    check("clr+err n", int'(o_n[1]), 0);
    check("clr+err field", int'(o_fld[1]), 2);
    spb(1'b1, NONE);
    do_clear();

    // Dominant CRC delimiter without sp changes nothing; short EOF config
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, CRC, 1'b0);
    check("nosp n", int'(o_n[0]), 1);
    check("nosp pulse", int'(o_p[0]), 0);
    check("nosp cnt", int'(o_cnt[0]), 0);
    for (int i = 1; i <= 3; i++) begin
      spb(1'b1, EOF);
      check($sformatf("eof3 done k=%0d", i), int'(o_done[2]), (i == 3) ? 1 : 0);
    end
    spb(1'b1, NONE);

    // Random traffic with sticky fields so EOF runs reach their end
    for (int n = 0; n < 4000; n++) begin
      logic [1:0] f;
      f = field;
      if ($urandom_range(99) < 20) f = 2'($urandom_range(3));
      if ($urandom_range(99) < 2) receiver_mode = ~receiver_mode;
      if ($urandom_range(999) < 3) begin
        reset = 1'b1;
        @(negedge clk); #1 reset = 1'b0;
      end
      cyc(1'($urandom_range(1)), ($urandom_range(99) >= 20), f,
          ($urandom_range(99) < 3));
    end

    cyc(1'b0, 1'b1, NONE, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/can_form_checker.md
Name: can_form_checker

Overview:
- Parametrised CAN form-error checker.
- Sits beside the bit-stream decoder.
- At each sample point it checks the fixed-form fields: CRC delimiter, ACK delimiter and End-of-Frame. It flags any illegal dominant bit and applies the receiver last-EOF-bit overload exception.
- Adds an internal EOF bit counter, a sticky or auto-release error mode, error-field capture and a saturating error counter.

Parameters:
- EOF_LEN, 7, number of recessive EOF bits checked (range 2..15).
- CNT_W, 8, width of the saturating form-error counter.
- ERR_LATCH, 1: 1 = form_err_n stays low until clear; 0 = released on return to IDLE.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- sp  in  1  sample-point strobe, one clk cycle wide, in the clk domain
- rx  in  1  sampled bus level (0 = dominant)
- field  in  2  current field from decoder: 0 NONE, 1 CRC_DELIM, 2 ACK_DELIM, 3 EOF
- receiver_mode  in  1  1 = node is receiver (last-EOF-bit exception enabled)
- clear  in  1  synchronous clear of flag, captured field and counter
- form_err_n  out  1  form-error flag, active low
- form_err_pulse  out  1  one-cycle pulse per detected form error
- err_field  out  2  field code of the most recent form error
- overload_req  out  1  one-cycle pulse: dominant bit in the last EOF bit as receiver
- eof_done  out  1  one-cycle pulse when EOF bit EOF_LEN has been sampled without form error
- err_count  out  CNT_W  saturating count of form errors

Behaviour:
- Reset values (async, any time, including mid-frame):
  - form_err_n=1; form_err_pulse=0; overload_req=0; eof_done=0.
  - err_field=0; err_count=0; state=IDLE; eof_cnt=0.
- Timing:
  - All evaluation happens on a rising clk edge with sp=1. Cycles with sp=0 change nothing except clear handling and pulse deassertion.
  - All outputs are registered. Latency is 1 clk from the sp cycle to the output change.
  - Pulses are exactly 1 clk wide.
- States: IDLE, CHECK, ERROR. IDLE→CHECK on sp with field≠NONE; CHECK→IDLE on sp with field=NONE.
- Check rules, applied in IDLE/CHECK on sp:
  - field=CRC_DELIM or ACK_DELIM with rx=0 → form error.
  - field=EOF: eof_cnt increments to give bit index k=1..EOF_LEN.
    - rx=0 with k<EOF_LEN → form error.
    - rx=0 with k=EOF_LEN and receiver_mode=0 → form error.
    - rx=0 with k=EOF_LEN and receiver_mode=1 → overload_req pulse, no error.
  - k=EOF_LEN with no form error → eof_done pulse. This includes the overload case.
  - EOF bits beyond EOF_LEN are not checked; eof_cnt holds at EOF_LEN.
  - eof_cnt clears on any sp with field≠EOF.
- On form error:
  - form_err_pulse=1, form_err_n=0, err_field=field.
  - err_count increments, saturating at 2^CNT_W−1.
  - State goes to ERROR.
- ERROR state:
  - Further dominant bits are ignored: no pulse, no count.
  - Leave to IDLE on sp with field=NONE.
  - ERR_LATCH=0: form_err_n returns to 1 on that transition.
  - ERR_LATCH=1: form_err_n is held low until clear.
- clear:
  - Sets form_err_n=1, err_field=0, err_count=0. State and eof_cnt are unaffected.
  - clear and a new error in the same cycle: the error wins the flag (form_err_n=0), err_field=new field, err_count=1.
- field changing between sp strobes has no effect; only the value at sp is used.
- Reset mid-EOF: the counter restarts from 0; the next EOF begins at k=1.

Test Plan:
- Reset asserted mid-EOF (k=4), released, then a full recessive 7-bit EOF → eof_done after the 7th sp only; form_err_n=1; err_count=0.
- sp with field=ACK_DELIM, rx=0 → next clk form_err_pulse=1, form_err_n=0, err_field=2, err_count=1. A second dominant sample in ERROR → err_count stays 1.
- EOF with rx=0 at k=7, receiver_mode=1 → overload_req pulse, eof_done pulse, no error. Same with receiver_mode=0 → form_err_pulse, err_field=3.
- ERR_LATCH=0: CRC_DELIM error, then sp with field=NONE → form_err_n back to 1. ERR_LATCH=1: it stays 0 until a clear pulse.
- CNT_W=2: 5 separate frames each with an ACK_DELIM error → err_count=3 (saturated). clear in the same cycle as a 6th error → err_count=1, form_err_n=0.
- sp=0 with rx=0 and field=CRC_DELIM for several cycles → no output change; EOF_LEN=3 EOF → eof_done after the 3rd recessive sp.
